muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply / divide unit. One iteration per clock, so
//   every operation takes a fixed WIDTH+2 edges from acceptance to the done
//   pulse, whatever the data.
//
//   op encoding: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     multiply: {Hi,Lo} = full 2*WIDTH-bit product
//     divide  : Lo = quotient (truncated toward zero),
//               Hi = remainder (takes the sign of the dividend)
//     divide by zero: DivZero=1, Lo = all ones, Hi = dividend as given
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high
//   start    in   request strobe; accepted only when busy=0
//   op       in   [1:0] operation select
//   DataA    in   [WIDTH-1:0] multiplicand / dividend
//   DataB    in   [WIDTH-1:0] multiplier / divisor
//   busy     out  operation in progress (CALC or FIX)
//   done     out  one-cycle pulse, results valid
//   Hi       out  [WIDTH-1:0] product upper half / remainder
//   Lo       out  [WIDTH-1:0] product lower half / quotient
//   DivZero  out  last completed division had a zero divisor
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    count_reg;
    logic             is_div_reg;
    logic             neg_q_reg;     // negate product / quotient in FIX
    logic             neg_r_reg;     // negate remainder in FIX
    logic             zero_div_reg;  // divisor was zero
    logic [WIDTH-1:0] a_raw_reg;     // dividend as given, for divide-by-zero
    logic [WIDTH-1:0] mag_reg;       // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc_reg;       // product upper half / partial remainder
    logic [WIDTH-1:0] low_reg;       // multiplier / dividend, shifted out as result builds
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             div_zero_reg;

    // ---------------------------------------------------------------
    // Acceptance and operand preparation
    // ---------------------------------------------------------------
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last_iter;

    assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_iter = (count_reg == CW'(WIDTH - 1));

    // Signed ops work on magnitudes. The most negative value negates to
    // itself, which read as unsigned is exactly its magnitude.
    assign a_neg = op[0] & DataA[WIDTH-1];
    assign b_neg = op[0] & DataB[WIDTH-1];
    assign a_mag = a_neg ? (~DataA + 1'b1) : DataA;
    assign b_mag = b_neg ? (~DataB + 1'b1) : DataB;

    // ---------------------------------------------------------------
    // One radix-2 step for each operation
    // ---------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the whole {acc,low} pair right. acc carries one spare bit for the carry.
    assign mul_sum   = acc_reg + (low_reg[0] ? {1'b0, mag_reg} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // naturally yields an all-ones quotient.
    assign div_shift = {acc_reg[WIDTH-1:0], low_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_reg});
    assign div_diff  = div_shift - {1'b0, mag_reg};

    // ---------------------------------------------------------------
    // Sign fix-up of the final magnitudes
    // ---------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_mag = {acc_reg[WIDTH-1:0], low_reg};
    assign prod_fix = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix  = neg_q_reg ? (~low_reg + 1'b1) : low_reg;
    assign rem_fix  = neg_r_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];

    // ---------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = accept ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            zero_div_reg <= 1'b0;
            a_raw_reg    <= '0;
            mag_reg      <= '0;
            acc_reg      <= '0;
            low_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        count_reg    <= '0;
                        is_div_reg   <= op[1];
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        zero_div_reg <= (DataB == '0);
                        a_raw_reg    <= DataA;
                        acc_reg      <= '0;
                        if (op[1]) begin
                            low_reg <= a_mag;
                            mag_reg <= b_mag;
                        end else begin
                            low_reg <= b_mag;
                            mag_reg <= a_mag;
                        end
                    end
                end
                CALC: begin
                    count_reg <= count_reg + CW'(1);
                    if (is_div_reg) begin
                        acc_reg <= div_ge ? div_diff : div_shift;
                        low_reg <= {low_reg[WIDTH-2:0], div_ge};
                    end else begin
                        acc_reg <= {1'b0, mul_sum[WIDTH:1]};
                        low_reg <= {mul_sum[0], low_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!is_div_reg) begin
                        hi_reg       <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg       <= prod_fix[WIDTH-1:0];
                        div_zero_reg <= 1'b0;
                    end else if (zero_div_reg) begin
                        hi_reg       <= a_raw_reg;
                        lo_reg       <= '1;
                        div_zero_reg <= 1'b1;
                    end else begin
                        hi_reg       <= rem_fix;
                        lo_reg       <= quo_fix;
                        div_zero_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg == CALC) || (state_reg == FIX);
    assign done    = (state_reg == DONE);
    assign Hi      = hi_reg;
    assign Lo      = lo_reg;
    assign DivZero = div_zero_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (WIDTH=32): reset state, a table of
//   hand-computed vectors, randomized operations against a 64-bit arithmetic
//   reference model, and hand-written sequences for ignored starts, restart
//   during DONE, and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] DataA, DataB;
    logic         busy, done, DivZero;
    logic [W-1:0] Hi, Lo;

    int vectors     = 0;
    int miscompares = 0;

    // values the outputs must hold while an operation is in flight
    logic [W-1:0] snap_hi, snap_lo;
    logic         snap_dz;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .DataA  (DataA),
        .DataB  (DataB),
        .busy   (busy),
        .done   (done),
        .Hi     (Hi),
        .Lo     (Lo),
        .DivZero(DivZero)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic. SystemVerilog signed division
    // truncates toward zero and % follows the dividend sign.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p  = 64'd0;
        case (o)
            2'd0: p = {32'd0, a} * {32'd0, b};
            2'd1: p = 64'(sa * sb);
            default: ;
        endcase
        hi = p[63:32];
        lo = p[31:0];
        if (o[1]) begin
            if (b == 0) begin
                dz = 1'b1;
                hi = a;
                lo = '1;
            end else if (o == 2'd2) begin
                lo = a / b;
                hi = a % b;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end
        end
    endfunction

    // Drive a request now; returns at the negedge after the sampling edge.
    task automatic launch_now(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        snap_hi = Hi;
        snap_lo = Lo;
        snap_dz = DivZero;
        op      = o;
        DataA   = a;
        DataB   = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Count edges until done, starting from n0 edges already elapsed.
    // busy must stay high and results must stay frozen until done.
    task automatic wait_done(input int n0, input int exp_lat, input string name);
        int   n;
        int   bad_busy;
        int   bad_hold;
        logic got;
        n        = n0;
        bad_busy = 0;
        bad_hold = 0;
        got      = 1'b0;
        if (n0 == 0 && busy !== 1'b1) bad_busy++;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
            else begin
                if (busy !== 1'b1) bad_busy++;
                if (Hi !== snap_hi || Lo !== snap_lo || DivZero !== snap_dz) bad_hold++;
            end
        end
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_busy_in_flight"}, 64'(bad_busy), 64'd0);
        check({name, "_hold_in_flight"}, 64'(bad_hold), 64'd0);
        if (got) check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        @(negedge clk);
        launch_now(o, a, b);
        wait_done(0, W + 1, name);
        check({name, "_Hi"}, 64'(Hi), 64'(ehi));
        check({name, "_Lo"}, 64'(Lo), 64'(elo));
        check({name, "_DivZero"}, 64'(DivZero), 64'(edz));
        $display("%s op=%0d A=%h B=%h -> Hi=%h Lo=%h DivZero=%b", name, o, a, b, Hi, Lo, DivZero);
    endtask

    initial begin
        logic [W-1:0] rhi, rlo, ra, rb;
        logic         rdz;
        logic [1:0]   rop;
        int           done_seen;

        tbl[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tbl[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[4]  = '{2'd2, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{2'd0, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        tbl[6]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[7]  = '{2'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tbl[8]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[9]  = '{2'd1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0};
        tbl[10] = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[11] = '{2'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
        tbl[12] = '{2'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[13] = '{2'd0, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        DataA = '0;
        DataB = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_Hi", 64'(Hi), 64'd0);
        check("reset_Lo", 64'(Lo), 64'd0);
        check("reset_DivZero", 64'(DivZero), 64'd0);
        reset = 1'b0;

        // table vectors
        for (int i = 0; i < 14; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz);

        // randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, rhi, rlo, rdz);
            run_op($sformatf("rand%0d", i), rop, ra, rb, rhi, rlo, rdz);
        end

        // second start while busy is ignored; third start during DONE accepted
        @(negedge clk);
        launch_now(2'd0, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        op    = 2'd0;
        DataA = 32'd9;
        DataB = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, W + 1, "ignored_start");
        check("ignored_start_Lo", 64'(Lo), 64'd6);
        check("ignored_start_Hi", 64'(Hi), 64'd0);
        $display("ignored_start op=0 A=2 B=3 (A=9 B=9 while busy) -> Hi=%h Lo=%h", Hi, Lo);
        launch_now(2'd0, 32'd9, 32'd9);
        check("restart_no_double_done", 64'(done), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        wait_done(1, W + 2, "restart_in_done");
        check("restart_in_done_Lo", 64'(Lo), 64'd81);
        $display("restart_in_done op=0 A=9 B=9 -> Hi=%h Lo=%h", Hi, Lo);

        // reset mid-operation
        run_op("pre_reset", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("pre_reset_dz", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        launch_now(2'd0, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_Hi", 64'(Hi), 64'd0);
        check("midreset_Lo", 64'(Lo), 64'd0);
        check("midreset_DivZero", 64'(DivZero), 64'd0);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("midreset_no_done", 64'(done_seen), 64'd0);
        $display("midreset op=0 A=5 B=5 aborted, done pulses seen=%0d", done_seen);

        // start at the first edge with reset low is accepted
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        launch_now(2'd3, 32'hFFFFFFF9, 32'd2);
        wait_done(0, W + 1, "post_reset_start");
        check("post_reset_start_Lo", 64'(Lo), 64'hFFFFFFFD);
        check("post_reset_start_Hi", 64'(Hi), 64'hFFFFFFFF);
        $display("post_reset_start op=3 A=fffffff9 B=2 -> Hi=%h Lo=%h", Hi, Lo);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
